// File: rtl/alu_seq_pkg.sv
// Shared encodings for the MIPS execute sequencer: opcode/funct values,
// ALU control codes, FSM states and instruction kinds.
package alu_seq_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  typedef enum logic [1:0] {
    K_RTYPE   = 2'd0,
    K_ITYPE   = 2'd1,
    K_BRANCH  = 2'd2,
    K_ILLEGAL = 2'd3
  } kind_e;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational MIPS decode: instr -> ALU control, extended immediate, dest, kind.
// Define ALU_SEQ_BNE_EN to decode bne (0x05) as a branch; otherwise it is illegal.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  alu_control,
  output logic        use_imm,
  output logic [31:0] imm_ext,
  output logic [31:0] branch_offset,
  output logic [4:0]  dest,
  output logic [1:0]  kind,
  output logic        is_bne
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [15:0] imm_s;

  assign opcode_s      = instr[31:26];
  assign funct_s       = instr[5:0];
  assign imm_s         = instr[15:0];
  assign branch_offset = {{14{imm_s[15]}}, imm_s, 2'b00};

  // Opcode/funct decode; unlisted encodings fall through as illegal
  always_comb begin
    alu_control = ALU_ADD;
    use_imm     = 1'b0;
    imm_ext     = {{16{imm_s[15]}}, imm_s};
    dest        = instr[15:11];
    kind        = K_ILLEGAL;
    is_bne      = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        kind = K_RTYPE;
        case (funct_s)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: kind = K_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        alu_control = ALU_ADD;
        use_imm     = 1'b1;
        dest        = instr[20:16];
        kind        = K_ITYPE;
      end
      OP_ANDI: begin
        alu_control = ALU_AND;
        use_imm     = 1'b1;
        imm_ext     = {16'h0000, imm_s};
        dest        = instr[20:16];
        kind        = K_ITYPE;
      end
      OP_ORI: begin
        alu_control = ALU_OR;
        use_imm     = 1'b1;
        imm_ext     = {16'h0000, imm_s};
        dest        = instr[20:16];
        kind        = K_ITYPE;
      end
      OP_BEQ: begin
        alu_control = ALU_SUB;
        kind        = K_BRANCH;
      end
`ifdef ALU_SEQ_BNE_EN
      OP_BNE: begin
        alu_control = ALU_SUB;
        kind        = K_BRANCH;
        is_bne      = 1'b1;
      end
`endif
      default: kind = K_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Three-state execute controller driving the MIPS ALU and reporting writeback/branch.
// Optional bne support is enabled by defining ALU_SEQ_BNE_EN (see alu_seq_decode).
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic [31:0] branch_offset,
  output logic        illegal_op
);

  logic [2:0]  alu_control_s;
  logic        use_imm_s;
  logic [31:0] imm_ext_s;
  logic [31:0] branch_offset_s;
  logic [4:0]  dest_s;
  logic [1:0]  kind_s;
  logic        is_bne_s;

  state_e      state_r, next_state_s;
  logic        accept_s;
  logic        instr_ready_r;
  logic [31:0] operand_a_r, operand_b_r;
  logic [2:0]  alu_control_r;
  logic [4:0]  dest_r;
  logic [1:0]  kind_r;
  logic [31:0] offset_r;
  logic        bne_r;
  logic        wb_valid_r, branch_valid_r, branch_taken_r, illegal_r;
  logic [4:0]  wb_reg_r;
  logic [31:0] wb_data_r, branch_offset_r;

  alu_seq_decode u_decode (
    .instr         (instr),
    .alu_control   (alu_control_s),
    .use_imm       (use_imm_s),
    .imm_ext       (imm_ext_s),
    .branch_offset (branch_offset_s),
    .dest          (dest_s),
    .kind          (kind_s),
    .is_bne        (is_bne_s)
  );

  // Next-state logic; illegal instructions bypass EXEC
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = instr_valid & instr_ready_r;
        if (accept_s) begin
          if (kind_s == K_ILLEGAL) next_state_s = RESP;
          else                     next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC:    next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register; ready is registered so it stays low throughout reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      instr_ready_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      instr_ready_r <= (next_state_s == IDLE);
    end
  end

  // Capture decode and operands on accept; ALU inputs hold otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand_a_r   <= 32'd0;
      operand_b_r   <= 32'd0;
      alu_control_r <= 3'd0;
      dest_r        <= 5'd0;
      kind_r        <= 2'd0;
      offset_r      <= 32'd0;
      bne_r         <= 1'b0;
    end else if (accept_s && (kind_s != K_ILLEGAL)) begin
      operand_a_r   <= rs_data;
      operand_b_r   <= use_imm_s ? imm_ext_s : rt_data;
      alu_control_r <= alu_control_s;
      dest_r        <= dest_s;
      kind_r        <= kind_s;
      offset_r      <= branch_offset_s;
      bne_r         <= is_bne_s;
    end
  end

  // Response pulses and result capture at the end of EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_r      <= 1'b0;
      branch_valid_r  <= 1'b0;
      branch_taken_r  <= 1'b0;
      illegal_r       <= 1'b0;
      wb_reg_r        <= 5'd0;
      wb_data_r       <= 32'd0;
      branch_offset_r <= 32'd0;
    end else begin
      wb_valid_r     <= 1'b0;
      branch_valid_r <= 1'b0;
      illegal_r      <= accept_s && (kind_s == K_ILLEGAL);
      if (state_r == EXEC) begin
        if (kind_r == K_BRANCH) begin
          branch_valid_r  <= 1'b1;
          branch_taken_r  <= alu_zero ^ bne_r;
          branch_offset_r <= offset_r;
        end else begin
          wb_valid_r <= (dest_r != 5'd0);
          wb_reg_r   <= dest_r;
          wb_data_r  <= alu_result;
        end
      end
    end
  end

  assign instr_ready   = instr_ready_r;
  assign alu_operand_a = operand_a_r;
  assign alu_operand_b = operand_b_r;
  assign alu_control   = alu_control_r;
  assign wb_valid      = wb_valid_r;
  assign wb_reg        = wb_reg_r;
  assign wb_data       = wb_data_r;
  assign branch_valid  = branch_valid_r;
  assign branch_taken  = branch_taken_r;
  assign branch_offset = branch_offset_r;
  assign illegal_op    = illegal_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; inputs driven and outputs
// sampled on the falling clock edge.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        illegal_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_control   (alu_control),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .branch_valid  (branch_valid),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .illegal_op    (illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction at a falling edge; returns at the next falling edge.
  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr       = i;
    rs_data     = a;
    rt_data     = b;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    rs_data     = 32'd0;
    rt_data     = 32'd0;
    alu_result  = 32'd0;
    alu_zero    = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_ready",   {31'd0, instr_ready}, 32'd0);
    check("rst_wb",      {31'd0, wb_valid}, 32'd0);
    check("rst_ctrl",    {29'd0, alu_control}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready",   {31'd0, instr_ready}, 32'd1);

    // Reset in the middle of EXEC of add $3,$1,$2
    send(32'h0022_1820, 32'd5, 32'd7);
    check("mid_exec_ctrl", {29'd0, alu_control}, 32'd2);
    alu_result = 32'd12;
    #2 reset_n = 1'b0;
    #1 check("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("mid_rst_wb2", {31'd0, wb_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_wb",    {31'd0, wb_valid}, 32'd0);
    check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("post_rst_opa",   alu_operand_a, 32'd0);
    check("post_rst_wbd",   wb_data, 32'd0);
    check("post_rst_ctrl",  {29'd0, alu_control}, 32'd0);

    // add $3,$1,$2 : 5 + 7 = 12; a held valid during EXEC must be ignored
    send(32'h0022_1820, 32'd5, 32'd7);
    check("add_ctrl",  {29'd0, alu_control}, 32'd2);
    check("add_opa",   alu_operand_a, 32'd5);
    check("add_opb",   alu_operand_b, 32'd7);
    check("add_busy",  {31'd0, instr_ready}, 32'd0);
    alu_result  = 32'd12;
    alu_zero    = 1'b0;
    instr       = 32'h8C22_0000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("add_wbv",   {31'd0, wb_valid}, 32'd1);
    check("add_wbr",   {27'd0, wb_reg}, 32'd3);
    check("add_wbd",   wb_data, 32'd12);
    check("add_brv",   {31'd0, branch_valid}, 32'd0);
    check("add_ill",   {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    check("add_ready", {31'd0, instr_ready}, 32'd1);
    check("add_wbv_off", {31'd0, wb_valid}, 32'd0);
    check("add_wbd_hold", wb_data, 32'd12);

    // addi $4,$0,-1 : sign-extended immediate
    send(32'h2004_FFFF, 32'd0, 32'h1234_5678);
    check("addi_ctrl", {29'd0, alu_control}, 32'd2);
    check("addi_opb",  alu_operand_b, 32'hFFFF_FFFF);
    alu_result = 32'hFFFF_FFFF;
    @(negedge clk);
    check("addi_wbv",  {31'd0, wb_valid}, 32'd1);
    check("addi_wbr",  {27'd0, wb_reg}, 32'd4);
    check("addi_wbd",  wb_data, 32'hFFFF_FFFF);
    @(negedge clk);

    // ori $4,$0,0xFFFF : zero-extended immediate
    send(32'h3404_FFFF, 32'd0, 32'd0);
    check("ori_ctrl",  {29'd0, alu_control}, 32'd1);
    check("ori_opb",   alu_operand_b, 32'h0000_FFFF);
    alu_result = 32'h0000_FFFF;
    @(negedge clk);
    check("ori_wbd",   wb_data, 32'h0000_FFFF);
    @(negedge clk);

    // andi $4,$0,0x8000 and sub $5,$6,$7 control codes
    send(32'h3004_8000, 32'd0, 32'd0);
    check("andi_ctrl", {29'd0, alu_control}, 32'd0);
    check("andi_opb",  alu_operand_b, 32'h0000_8000);
    @(negedge clk);
    @(negedge clk);
    send(32'h00C7_2822, 32'd9, 32'd4);
    check("sub_ctrl",  {29'd0, alu_control}, 32'd6);
    @(negedge clk);
    @(negedge clk);
    send(32'h00C7_282A, 32'd9, 32'd4);
    check("slt_ctrl",  {29'd0, alu_control}, 32'd7);
    @(negedge clk);
    @(negedge clk);

    // beq $1,$2,-2 with equal operands
    send(32'h1022_FFFE, 32'd9, 32'd9);
    check("beq_ctrl",  {29'd0, alu_control}, 32'd6);
    check("beq_opa",   alu_operand_a, 32'd9);
    check("beq_opb",   alu_operand_b, 32'd9);
    alu_result = 32'd0;
    alu_zero   = 1'b1;
    @(negedge clk);
    check("beq_brv",   {31'd0, branch_valid}, 32'd1);
    check("beq_taken", {31'd0, branch_taken}, 32'd1);
    check("beq_off",   branch_offset, 32'hFFFF_FFF8);
    check("beq_wbv",   {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("beq_brv_off", {31'd0, branch_valid}, 32'd0);
    check("beq_off_hold", branch_offset, 32'hFFFF_FFF8);

    // add $0,$1,$2 : write suppressed, still three cycles
    alu_zero = 1'b0;
    send(32'h0022_0020, 32'd1, 32'd2);
    alu_result = 32'd3;
    @(negedge clk);
    check("zero_wbv",   {31'd0, wb_valid}, 32'd0);
    check("zero_brv",   {31'd0, branch_valid}, 32'd0);
    check("zero_busy",  {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check("zero_ready", {31'd0, instr_ready}, 32'd1);

    // opcode 0x23 : illegal, two-cycle turnaround, ALU inputs held
    send(32'h8C22_0000, 32'd77, 32'd88);
    check("ill_pulse", {31'd0, illegal_op}, 32'd1);
    check("ill_wbv",   {31'd0, wb_valid}, 32'd0);
    check("ill_brv",   {31'd0, branch_valid}, 32'd0);
    check("ill_busy",  {31'd0, instr_ready}, 32'd0);
    check("ill_opa_hold", alu_operand_a, 32'd1);
    @(negedge clk);
    check("ill_ready", {31'd0, instr_ready}, 32'd1);
    check("ill_off",   {31'd0, illegal_op}, 32'd0);

    // bne $1,$2,4 with unequal operands
    send(32'h1422_0004, 32'd1, 32'd2);
`ifdef ALU_SEQ_BNE_EN
    check("bne_ctrl",  {29'd0, alu_control}, 32'd6);
    alu_result = 32'hFFFF_FFFF;
    alu_zero   = 1'b0;
    @(negedge clk);
    check("bne_brv",   {31'd0, branch_valid}, 32'd1);
    check("bne_taken", {31'd0, branch_taken}, 32'd1);
    check("bne_off",   branch_offset, 32'h0000_0010);
    @(negedge clk);
`else
    check("bne_ill",   {31'd0, illegal_op}, 32'd1);
    check("bne_brv",   {31'd0, branch_valid}, 32'd0);
    @(negedge clk);
`endif
    check("final_ready", {31'd0, instr_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
